// File: rtl/moore.sv
// Moore-style detector for serial pattern 1101 (first bit first); dout is decoded from the state register only.
// Latency: dout is high in the cycle after the edge that samples the final '1'. No backpressure: din is consumed every edge.
module moore #(
    parameter int OVERLAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S11   = 3'd2,
        S110  = 3'd3,
        S1101 = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:    state_d = din ? S1    : S0;
            S1:    state_d = din ? S11   : S0;
            S11:   state_d = din ? S11   : S110;
            S110:  state_d = din ? S1101 : S0;
            // After a match, the trailing '1' either continues as "11" or starts afresh as "1".
            S1101: state_d = din ? ((OVERLAP != 0) ? S11 : S1) : S0;
            default: state_d = S0;
        endcase
    end

    assign state = state_q;
    assign dout  = (state_q == S1101);

endmodule

// File: tb/tb_moore.sv
// Bench for moore: both OVERLAP settings side by side, checked against a pattern-history reference model.
module tb_moore;

    logic       clk;
    logic       reset;
    logic       din;
    logic       dout_o, dout_n;
    logic [2:0] state_o, state_n;

    int vectors;
    int miscompares;

    bit hist_o[$];
    bit hist_n[$];

    localparam logic [3:0] PAT = 4'b1101;

    moore #(.OVERLAP(1)) u_ovl (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout_o),
        .state (state_o)
    );

    moore #(.OVERLAP(0)) u_nov (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout_n),
        .state (state_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Length of the longest prefix of 1101 that ends the bit history.
    function automatic int match_len(input bit h[$]);
        for (int k = 4; k >= 1; k--) begin
            if (h.size() >= k) begin
                bit ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[h.size() - k + j] != PAT[3 - j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    // Apply one bit; din wiggles between edges first to show only the edge value matters.
    task automatic step(input bit b);
        int ko, kn;
        din = 1'($urandom);
        #2;
        din = ~din;
        #1;
        din = b;
        @(posedge clk);
        #1;
        hist_o.push_back(b);
        hist_n.push_back(b);
        if (hist_o.size() > 4) void'(hist_o.pop_front());
        ko = match_len(hist_o);
        kn = match_len(hist_n);
        check("ovl_state", 32'(state_o), 32'(ko));
        check("ovl_dout",  32'(dout_o),  32'(ko == 4));
        check("nov_state", 32'(state_n), 32'(kn));
        check("nov_dout",  32'(dout_n),  32'(kn == 4));
        if (kn == 4) hist_n.delete();
        if (hist_n.size() > 4) void'(hist_n.pop_front());
    endtask

    // Reset asserted between edges, held across an edge, released before the next edge.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_imm_state_o", 32'(state_o), 32'd0);
        check("rst_imm_dout_o",  32'(dout_o),  32'd0);
        check("rst_imm_state_n", 32'(state_n), 32'd0);
        check("rst_imm_dout_n",  32'(dout_n),  32'd0);
        din = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_state_o", 32'(state_o), 32'd0);
        check("rst_hold_state_n", 32'(state_n), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hist_o.delete();
        hist_n.delete();
    endtask

    int s19[16]    = '{1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};
    int e19[16]    = '{1,0,1,2,3,4,2,3,4,2,3,4,2,3,4,2};
    int s21[6]     = '{1,1,1,1,0,1};
    int e21[6]     = '{1,2,2,2,3,4};
    int s22[8]     = '{1,1,0,0,1,1,0,1};
    int e22[8]     = '{1,2,3,0,1,2,3,4};

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        din         = 1'b0;
        #1;
        check("por_state", 32'(state_o), 32'd0);
        check("por_dout",  32'(dout_o),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Mixed stream; explicit expectations alongside the model.
        for (int i = 0; i < 16; i++) begin
            step(bit'(s19[i]));
            check("s19_state_o", 32'(state_o), 32'(e19[i]));
            check("s19_dout_n",  32'(dout_n),  32'((i == 5) || (i == 11)));
            if (i == 6) check("s19_nov_e7", 32'(state_n), 32'd1);
            if (i == 7) check("s19_nov_e8", 32'(state_n), 32'd0);
        end

        mid_reset();
        for (int i = 0; i < 6; i++) begin
            step(bit'(s21[i]));
            check("s21_state_o", 32'(state_o), 32'(e21[i]));
        end

        mid_reset();
        for (int i = 0; i < 8; i++) begin
            step(bit'(s22[i]));
            check("s22_state_o", 32'(state_o), 32'(e22[i]));
        end

        // Abort from "110", then a lone '1' must not complete the old match.
        mid_reset();
        step(1'b1); step(1'b1); step(1'b0);
        check("s110_reached", 32'(state_o), 32'd3);
        mid_reset();
        step(1'b1);
        check("post_rst_state", 32'(state_o), 32'd1);
        check("post_rst_dout",  32'(dout_o),  32'd0);

        mid_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("zeros_state", 32'(state_o), 32'd0);
        end

        // Random traffic biased toward ones, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) mid_reset();
            step($urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/moore.md
MOORE -- requirements
Module: moore

Interface
REQ-001 Parameter OVERLAP, default 1, meaning: 1 = overlapping detection of pattern 1101; 0 = non-overlapping detection (search restarts after a match).
REQ-002 clk  input  1  rising-edge clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial data bit, sampled on each rising clk edge.
REQ-005 dout  output  1  detect flag; a function of the current state only (Moore), no combinational path from din.
REQ-006 state  output  3  current state register value, exposed directly for observation.

Function
REQ-007 The block SHALL be a Moore FSM detecting serial pattern 1,1,0,1, first bit received first.
REQ-008 State encoding SHALL be: S0=3'd0 (no progress), S1=3'd1 ("1"), S11=3'd2 ("11"), S110=3'd3 ("110"), S1101=3'd4 (match).
REQ-009 Transitions on din=0 / din=1 SHALL be: S0 -> S0 / S1; S1 -> S0 / S11; S11 -> S110 / S11; S110 -> S0 / S1101.
REQ-010 From S1101 with OVERLAP=1: din=0 -> S0, din=1 -> S11.
REQ-011 From S1101 with OVERLAP=0: din=0 -> S0, din=1 -> S1.
REQ-012 dout SHALL be 1 exactly when state==S1101, else 0; latency: dout rises in the cycle after the edge that samples the final '1' and lasts one cycle unless re-entered.
REQ-013 Unused codes 3'd5..3'd7 SHALL drive dout=0 and transition to S0 on the next rising edge regardless of din.
REQ-014 state and dout SHALL be glitch-free registered/decoded values; dout SHALL depend on no input other than the state register.
REQ-015 din is sampled only at rising clk edges; changes between edges SHALL have no effect.

Reset
REQ-016 While reset=1, state SHALL be S0 (3'd0) and dout SHALL be 0, immediately and independent of clk.
REQ-017 Reset asserted mid-sequence (any state, including S1101) SHALL abort progress; after release, detection restarts from S0 and requires a full new 1101.
REQ-018 On reset release, the first rising edge SHALL perform a normal transition from S0 using din.

Verification
REQ-019 Reset high, then low; stream din = 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 (one bit per rising edge), OVERLAP=1 -> state after edges 1..16 = 1,0,1,2,3,4,2,3,4,2,3,4,2,3,4,2; dout=1 only after edges 6, 9, 12, 15.
REQ-020 Same stream, OVERLAP=0 -> dout=1 only after edges 6 and 12; state after edge 7 = 1, after edge 8 = 0.
REQ-021 Stream 1,1,1,1,0,1 -> state holds 2 through the repeated 1s, then 3, then 4; dout=1 after edge 6 only.
REQ-022 Stream 1,1,0,0,1,1,0,1 -> state 1,2,3,0,1,2,3,4; single detection after edge 8.
REQ-023 Drive input to reach S110 (state=3), assert reset between clock edges -> state=0 and dout=0 immediately; after release, din=1 gives state=1, not a detection.
REQ-024 All-zero stream for 8 edges -> state stays 0, dout stays 0.
